// File: rtl/kronos_mem_arbiter.sv
// Two-port (instruction fetch / load-store) arbiter in front of a single-ported SRAM.
// Data wins by default; a starved instruction port is forced through after STARVE_LIMIT denials.
module kronos_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rstz,

    input  logic [31:0] instr_addr,
    input  logic        instr_req,
    output logic        instr_gnt,
    output logic        instr_ack,
    output logic [31:0] instr_data,

    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_mask,
    input  logic        data_we,
    input  logic        data_req,
    output logic        data_gnt,
    output logic        data_ack,
    output logic [31:0] data_rdata,

    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_mask,
    input  logic [31:0] mem_rdata
);

    localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

    logic [3:0] starve_q, starve_d;
    logic       instr_ack_q, data_ack_q;
    logic       instr_force;

    always_comb begin
        instr_force = instr_req && (starve_q >= StarveMax);

        // Grants are gated by rstz so nothing is issued while reset is held.
        data_gnt  = rstz && data_req && !instr_force;
        instr_gnt = rstz && instr_req && !data_gnt;

        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_mask  = 4'h0;
        if (data_gnt) begin
            mem_en    = 1'b1;
            mem_we    = data_we;
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
            mem_mask  = data_mask;
        end else if (instr_gnt) begin
            mem_en    = 1'b1;
            mem_addr  = instr_addr;
            mem_mask  = 4'hF;
        end

        starve_d = 4'h0;
        if (instr_req && !instr_gnt) begin
            starve_d = (starve_q >= StarveMax) ? StarveMax : starve_q + 4'h1;
        end
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            starve_q    <= 4'h0;
            instr_ack_q <= 1'b0;
            data_ack_q  <= 1'b0;
        end else begin
            starve_q    <= starve_d;
            instr_ack_q <= instr_gnt;
            data_ack_q  <= data_gnt;
        end
    end

    assign instr_ack  = instr_ack_q;
    assign data_ack   = data_ack_q;
    assign instr_data = mem_rdata;
    assign data_rdata = mem_rdata;

endmodule

// File: tb/tb_kronos_mem_arbiter.sv
// Randomized and directed bench for kronos_mem_arbiter with a transaction-level reference model.
module tb_kronos_mem_arbiter;

    localparam int STARVE = 4;

    logic        clk = 1'b0;
    logic        rstz;
    logic [31:0] instr_addr, data_addr, data_wdata, mem_addr, mem_wdata, mem_rdata;
    logic        instr_req, data_req, data_we;
    logic [3:0]  data_mask, mem_mask;
    logic        instr_gnt, instr_ack, data_gnt, data_ack, mem_en, mem_we;
    logic [31:0] instr_data, data_rdata;

    kronos_mem_arbiter #(.STARVE_LIMIT(STARVE)) dut (
        .clk        (clk),
        .rstz       (rstz),
        .instr_addr (instr_addr),
        .instr_req  (instr_req),
        .instr_gnt  (instr_gnt),
        .instr_ack  (instr_ack),
        .instr_data (instr_data),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .data_mask  (data_mask),
        .data_we    (data_we),
        .data_req   (data_req),
        .data_gnt   (data_gnt),
        .data_ack   (data_ack),
        .data_rdata (data_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_mask   (mem_mask),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // SRAM environment: one-cycle read latency, byte-masked writes.
    logic [31:0] env_mem [1024];
    initial mem_rdata = 32'h0;
    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata <= env_mem[mem_addr[11:2]];
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_mask[b]) env_mem[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    // Reference model state
    logic [31:0] ref_mem [1024];
    int          denied;
    int          win;          // 0 none, 1 instr, 2 data
    bit          pend_i, pend_d, pend_store;
    logic [31:0] pend_data;
    bit          exp_igt, exp_dgt, exp_en, exp_we, exp_iack, exp_dack, exp_load_ack;
    logic [31:0] exp_addr, exp_rd;
    logic [3:0]  exp_mask;

    int n_vec = 0;
    int n_err = 0;

    task automatic predict();
        if (!rstz) win = 0;
        else if (instr_req && denied >= STARVE) win = 1;
        else if (data_req) win = 2;
        else if (instr_req) win = 1;
        else win = 0;
        exp_igt  = (win == 1);
        exp_dgt  = (win == 2);
        exp_en   = (win != 0);
        exp_we   = (win == 2) && data_we;
        exp_addr = (win == 1) ? instr_addr : data_addr;
        exp_mask = (win == 1) ? 4'hF : data_mask;
        exp_iack = rstz && pend_i;
        exp_dack = rstz && pend_d;
        exp_load_ack = (exp_iack || exp_dack) && !pend_store;
        exp_rd   = pend_data;
    endtask

    task automatic commit();
        if (!rstz) begin
            denied = 0; pend_i = 0; pend_d = 0; pend_store = 0;
        end else begin
            if (instr_req && win != 1) denied = (denied + 1 > STARVE) ? STARVE : denied + 1;
            else denied = 0;
            pend_i = (win == 1);
            pend_d = (win == 2);
            pend_store = (win == 2) && data_we;
            if (win != 0) pend_data = ref_mem[exp_addr[11:2]];
            if (pend_store)
                for (int b = 0; b < 4; b++)
                    if (data_mask[b]) ref_mem[data_addr[11:2]][8*b +: 8] = data_wdata[8*b +: 8];
        end
    endtask

    task automatic settle();
        #1;
        predict();
    endtask

    task automatic next_cycle();
        commit();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        instr_req = 0; data_req = 0; data_we = 0;
        instr_addr = 0; data_addr = 0; data_wdata = 0; data_mask = 0;
    endtask

    task automatic test_reset();
        rstz = 0;
        idle_inputs();
        instr_req = 1; data_req = 1;
        repeat (2) @(negedge clk);
        settle();
        n_vec++;
        if ({instr_gnt, data_gnt, mem_en, mem_we, instr_ack, data_ack} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b required 000000",
                     {instr_gnt, data_gnt, mem_en, mem_we, instr_ack, data_ack});
        end
        next_cycle();
        rstz = 1;
        idle_inputs();
        settle();
        n_vec++;
        if ({instr_ack, data_ack, mem_en} !== 3'b0) begin
            n_err++;
            $display("FAIL reset_release_idle: got %b required 000", {instr_ack, data_ack, mem_en});
        end
        next_cycle();
    endtask

    task automatic test_instr_stream();
        for (int k = 0; k < 4; k++) begin
            instr_req  = (k < 3);
            instr_addr = 32'(4 * k);
            settle();
            n_vec++;
            if (instr_gnt !== (k < 3) || data_gnt !== 1'b0) begin
                n_err++;
                $display("FAIL instr_stream_gnt[%0d]: got %b%b required %b0", k, instr_gnt,
                         data_gnt, k < 3);
            end
            n_vec++;
            if (instr_ack !== (k > 0)) begin
                n_err++;
                $display("FAIL instr_stream_ack[%0d]: got %b required %b", k, instr_ack, k > 0);
            end
            if (k > 0) begin
                n_vec++;
                if (instr_data !== exp_rd) begin
                    n_err++;
                    $display("FAIL instr_stream_data[%0d]: got %h required %h", k, instr_data, exp_rd);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_both_req();
        logic [31:0] want;
        want = ref_mem[32'h100 >> 2];
        instr_req = 1; instr_addr = 32'h40;
        data_req = 1; data_we = 0; data_addr = 32'h100;
        settle();
        n_vec++;
        if ({instr_gnt, data_gnt, mem_we} !== 3'b010 || mem_addr !== 32'h100) begin
            n_err++;
            $display("FAIL both_req_gnt: got %b addr %h required 010 addr 00000100",
                     {instr_gnt, data_gnt, mem_we}, mem_addr);
        end
        next_cycle();
        idle_inputs();
        settle();
        n_vec++;
        if ({instr_ack, data_ack} !== 2'b01 || data_rdata !== want) begin
            n_err++;
            $display("FAIL both_req_ack: got %b data %h required 01 data %h",
                     {instr_ack, data_ack}, data_rdata, want);
        end
        next_cycle();
    endtask

    task automatic test_starve();
        for (int k = 0; k < 7; k++) begin
            instr_req = 1; instr_addr = 32'h80;
            data_req = 1; data_we = 0; data_addr = 32'(32'h180 + 4 * k);
            settle();
            n_vec++;
            if (instr_gnt !== (k == STARVE) || data_gnt !== (k != STARVE)) begin
                n_err++;
                $display("FAIL starve[%0d]: got igt %b dgt %b required igt %b dgt %b", k,
                         instr_gnt, data_gnt, k == STARVE, k != STARVE);
            end
            next_cycle();
        end
        idle_inputs();
        settle();
        next_cycle();
    endtask

    task automatic test_store_load();
        logic [31:0] old;
        old = ref_mem[32'h200 >> 2];
        data_req = 1; data_we = 1; data_addr = 32'h200;
        data_wdata = 32'hDEADBEEF; data_mask = 4'b0011;
        settle();
        n_vec++;
        if ({data_gnt, mem_en, mem_we} !== 3'b111 || mem_mask !== 4'b0011 ||
            mem_wdata !== 32'hDEADBEEF || mem_addr !== 32'h200) begin
            n_err++;
            $display("FAIL store_issue: got gnt/en/we %b mask %b wdata %h addr %h",
                     {data_gnt, mem_en, mem_we}, mem_mask, mem_wdata, mem_addr);
        end
        next_cycle();
        data_we = 0; data_mask = 4'h0; data_wdata = 0;
        settle();
        n_vec++;
        if (data_ack !== 1'b1 || data_gnt !== 1'b1) begin
            n_err++;
            $display("FAIL store_ack: got ack %b gnt %b required 1 1", data_ack, data_gnt);
        end
        next_cycle();
        idle_inputs();
        settle();
        n_vec++;
        if (data_ack !== 1'b1 || data_rdata !== {old[31:16], 16'hBEEF}) begin
            n_err++;
            $display("FAIL store_readback: got ack %b data %h required 1 %h", data_ack,
                     data_rdata, {old[31:16], 16'hBEEF});
        end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        instr_req = 1; instr_addr = 32'h10;
        settle();
        n_vec++;
        if (instr_gnt !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_gnt: got %b required 1", instr_gnt);
        end
        next_cycle();
        rstz = 0;
        settle();
        n_vec++;
        if ({instr_ack, instr_gnt, mem_en} !== 3'b000) begin
            n_err++;
            $display("FAIL rstmid_drop: got ack/gnt/en %b required 000",
                     {instr_ack, instr_gnt, mem_en});
        end
        next_cycle();
        rstz = 1; instr_addr = 32'h14;
        settle();
        n_vec++;
        if (instr_ack !== 1'b0 || instr_gnt !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_resume: got ack %b gnt %b required 0 1", instr_ack, instr_gnt);
        end
        next_cycle();
        idle_inputs();
        settle();
        n_vec++;
        if (instr_ack !== 1'b1 || instr_data !== exp_rd) begin
            n_err++;
            $display("FAIL rstmid_ack: got ack %b data %h required 1 %h", instr_ack,
                     instr_data, exp_rd);
        end
        next_cycle();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            instr_req  = ($urandom_range(0, 9) < 7);
            data_req   = ($urandom_range(0, 9) < 6);
            data_we    = $urandom_range(0, 1);
            instr_addr = {20'h0, 10'($urandom), 2'b00};
            data_addr  = {20'h0, 10'($urandom_range(0, 31)), 2'b00};
            data_wdata = $urandom;
            data_mask  = 4'($urandom);
            settle();
            n_vec++;
            if ({instr_gnt, data_gnt, mem_en, mem_we} !== {exp_igt, exp_dgt, exp_en, exp_we}) begin
                n_err++;
                $display("FAIL rand_gnt[%0d]: got %b required %b", k,
                         {instr_gnt, data_gnt, mem_en, mem_we}, {exp_igt, exp_dgt, exp_en, exp_we});
            end
            if (exp_en) begin
                n_vec++;
                if (mem_addr !== exp_addr || mem_mask !== exp_mask ||
                    (exp_we && mem_wdata !== data_wdata)) begin
                    n_err++;
                    $display("FAIL rand_mem[%0d]: got addr %h mask %h wdata %h required %h %h %h",
                             k, mem_addr, mem_mask, mem_wdata, exp_addr, exp_mask, data_wdata);
                end
            end
            n_vec++;
            if ({instr_ack, data_ack} !== {exp_iack, exp_dack}) begin
                n_err++;
                $display("FAIL rand_ack[%0d]: got %b required %b", k, {instr_ack, data_ack},
                         {exp_iack, exp_dack});
            end
            if (exp_load_ack) begin
                n_vec++;
                if (instr_data !== exp_rd || data_rdata !== exp_rd) begin
                    n_err++;
                    $display("FAIL rand_data[%0d]: got %h/%h required %h", k, instr_data,
                             data_rdata, exp_rd);
                end
            end
            next_cycle();
        end
        idle_inputs();
        settle();
        next_cycle();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ref_mem[i] = $urandom;
            env_mem[i] = ref_mem[i];
        end
        denied = 0; pend_i = 0; pend_d = 0; pend_store = 0; pend_data = 0; win = 0;
        @(negedge clk);
        test_reset();
        test_instr_stream();
        test_both_req();
        test_starve();
        test_store_load();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/kronos_mem_arbiter.md
KRONOS_MEM_ARBITER -- requirements
Module: kronos_mem_arbiter

Interface
REQ-001 The block SHALL declare parameter STARVE_LIMIT, default 4, meaning the number of consecutive cycles the instruction port may be denied before it is forced priority (legal range 1-15).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state is rising-edge triggered.
REQ-003 The block SHALL have port rstz, input, 1, the reset: asynchronous and active-low.
REQ-004 The block SHALL have port instr_addr, input, 32, instruction fetch word address.
REQ-005 The block SHALL have port instr_req, input, 1, instruction fetch request.
REQ-006 The block SHALL have port instr_gnt, output, 1, instruction request granted this cycle.
REQ-007 The block SHALL have port instr_ack, output, 1, fetch data valid.
REQ-008 The block SHALL have port instr_data, output, 32, fetched word.
REQ-009 The block SHALL have port data_addr, input, 32, load/store address.
REQ-010 The block SHALL have port data_wdata, input, 32, store data.
REQ-011 The block SHALL have port data_mask, input, 4, store byte enables.
REQ-012 The block SHALL have port data_we, input, 1, 1 = store, 0 = load.
REQ-013 The block SHALL have port data_req, input, 1, data request.
REQ-014 The block SHALL have port data_gnt, output, 1, data request granted this cycle.
REQ-015 The block SHALL have port data_ack, output, 1, load data valid or store complete.
REQ-016 The block SHALL have port data_rdata, output, 32, load word.
REQ-017 The block SHALL have port mem_en, output, 1, SRAM access enable.
REQ-018 The block SHALL have port mem_we, output, 1, SRAM write enable.
REQ-019 The block SHALL have port mem_addr, output, 32, SRAM address.
REQ-020 The block SHALL have port mem_wdata, output, 32, SRAM write data.
REQ-021 The block SHALL have port mem_mask, output, 4, SRAM byte enables.
REQ-022 The block SHALL have port mem_rdata, input, 32, SRAM read data, valid the cycle after an access.

Function
REQ-023 Arbitration SHALL be combinational per cycle: at most one of instr_gnt and data_gnt is 1, and a grant is given only to an asserted request.
REQ-024 Default priority SHALL be data over instruction.
REQ-025 When starve_cnt equals STARVE_LIMIT and instr_req=1, the instruction port SHALL win over data.
REQ-026 starve_cnt (4-bit) SHALL increment when instr_req=1 and instr_gnt=0, SHALL saturate at STARVE_LIMIT, and SHALL clear to 0 on any cycle with instr_gnt=1 or instr_req=0.
REQ-027 On a granted cycle, mem_en SHALL be 1 and mem_addr, mem_we, mem_wdata and mem_mask SHALL come from the winner.
REQ-028 On an instruction grant, mem_we SHALL be 0 and mem_mask SHALL be 4'hF.
REQ-029 On a cycle with no grant, mem_en SHALL be 0 and mem_we SHALL be 0.
REQ-030 Each grant SHALL be exactly one transaction; a request held high after a grant is a new transaction.
REQ-031 Back-to-back grants to either port SHALL be allowed with no bubble.
REQ-032 Latency SHALL be fixed at one cycle: a grant in cycle N produces a registered ack (instr_ack or data_ack) in cycle N+1 only.
REQ-033 instr_data and data_rdata SHALL both pass mem_rdata through combinationally.
REQ-034 On a store, data_ack SHALL still be asserted in N+1, and data_rdata is don't-care in that cycle.
REQ-035 A denied requester SHALL receive no ack in N+1; it may change or revert its address freely, because no state is held for ungranted requests.
REQ-036 When instr_req and data_req are both 0, starve_cnt SHALL hold 0 and no ack SHALL follow in the next cycle.

Reset
REQ-037 While rstz=0, instr_ack, data_ack, instr_gnt, data_gnt, mem_en and mem_we SHALL be 0, and starve_cnt SHALL be 0.
REQ-038 Reset asserted with an access outstanding SHALL drop its ack; no ack SHALL appear after reset release until a new grant.
REQ-039 In the first cycle after rstz rises, arbitration SHALL resume normally.

Verification
REQ-040 Scenario: instr_req=1 steady with instr_addr=0x0,0x4,0x8, data_req=0 -> instr_gnt=1 every cycle; instr_ack=1 from the second cycle, returning words at 0x0, 0x4, 0x8 in consecutive cycles.
REQ-041 Scenario: both requests in one cycle, data load 0x100 -> data_gnt=1, instr_gnt=0; next cycle data_ack=1, instr_ack=0, data_rdata=mem[0x100].
REQ-042 Scenario: data_req=1 continuously, instr_req=1, STARVE_LIMIT=4 -> instr denied 4 cycles, instr_gnt=1 on the 5th, then starve_cnt=0 and data wins again.
REQ-043 Scenario: store data_addr=0x200, data_wdata=0xDEADBEEF, data_mask=4'b0011 -> mem_we=1 and mem_mask=0011 in the grant cycle; data_ack=1 next cycle; a later load of 0x200 returns only the low halfword changed.
REQ-044 Scenario: rstz pulsed low the cycle after an instruction grant -> instr_ack stays 0, and the post-reset grant acks normally.
